// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver.
// Latches a packed BCD vector on load, applies it only at frame boundaries,
// and scans digits onto an active-low segment bus and one-hot active-low anodes
// with leading-zero blanking, per-digit blink, nibble blanking and a DP mask.
module seven_seg_scan_driver #(
    parameter int unsigned            NUM_DIGITS = 6,
    parameter int unsigned            SCAN_DIV   = 50000,
    parameter int unsigned            BLINK_DIV  = 64,
    parameter logic [NUM_DIGITS-1:0]  DP_MASK    = 6'b010100
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic                      blank_lz,
    input  logic [NUM_DIGITS-1:0]     blink_en,
    output logic [7:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_done
);

    localparam int unsigned PC_W  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FC_W  = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

    localparam logic [PC_W-1:0]       PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]       FC_LAST  = FC_W'(BLINK_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    logic [PC_W-1:0]         pc_q, pc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_v_q, pend_v_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [FC_W-1:0]         fc_q, fc_d;
    logic                    phase_q, phase_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q;

    logic                    pc_wrap;
    logic                    boundary;
    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic                    zero_run;
    logic                    lz_blank;
    logic                    blink_blank;

    function automatic logic [6:0] enc7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign pc_wrap  = (pc_q == PC_LAST);
    assign boundary = pc_wrap && (idx_q == IDX_LAST);

    // Scan counters, pending/display hand-over at frame boundaries, blink timing.
    always_comb begin
        pc_d     = pc_wrap ? '0 : pc_q + 1'b1;
        idx_d    = idx_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        disp_d   = disp_q;
        fc_d     = fc_q;
        phase_d  = phase_q;

        if (pc_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // A load coinciding with the boundary bypasses the pending register.
        if (boundary) begin
            if (load) begin
                disp_d = bcd_in;
            end else if (pend_v_q) begin
                disp_d = pend_q;
            end
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_d   = bcd_in;
            pend_v_d = 1'b1;
        end

        if (boundary) begin
            if (fc_q == FC_LAST) begin
                fc_d    = '0;
                phase_d = ~phase_q;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    // Segment/anode decode from next-state values so outputs track idx exactly.
    always_comb begin
        nib        = disp_d[4*idx_d +: 4];
        upper_zero = '0;
        zero_run   = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            zero_run = zero_run && (disp_d[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            upper_zero[NUM_DIGITS-1-i] = zero_run;
        end
        lz_blank    = blank_lz && (idx_d != '0) && upper_zero[idx_d];
        blink_blank = blink_en[idx_d] && phase_d;
        an_d        = ~(AN_ONE << idx_d);
        seg_d       = '1;
        if (!(lz_blank || blink_blank || (nib >= 4'd10))) begin
            seg_d = {~DP_MASK[idx_d], enc7(nib)};
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            idx_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            disp_q   <= '1;
            fc_q     <= '0;
            phase_q  <= 1'b0;
            seg_q    <= '1;
            an_q     <= '1;
            fd_q     <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            disp_q   <= disp_d;
            fc_q     <= fc_d;
            phase_q  <= phase_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            fd_q     <= boundary;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign frame_done = fd_q;

endmodule
